// File: rtl/utmi_pkg.sv
// rtl/utmi_pkg.sv - shared UTMI receive types and constants
package utmi_pkg;

  typedef enum logic [1:0] {
    RX_WAIT,
    RX_SYNC,
    RX_DATA,
    RX_ERR
  } rx_state_t;

  localparam logic [7:0] SYNC_BYTE        = 8'h80;
  localparam int         MAX_BYTES_DEF    = 1027;
  localparam int         IDLE_TIMEOUT_DEF = 16;
  localparam int         BCNT_W           = 11;

  // A USB PID carries its own check field: high nibble is the complement of the low nibble.
  function automatic logic pid_ok(input logic [7:0] b);
    return b[7:4] == ~b[3:0];
  endfunction

endpackage

// File: rtl/rx_fsm_if.sv
// rtl/rx_fsm_if.sv - receive chain to link layer byte interface
interface rx_fsm_if #(
  parameter int W = 8
);

  logic [W-1:0] rx_byte;
  logic         rx_byte_valid;
  logic         rx_line_active;
  logic         rx_se0;
  logic         rx_stuff_err;
  logic [W-1:0] rx_data;
  logic         rx_valid;
  logic         rx_active;
  logic         rx_error;

  modport master (
    output rx_byte, rx_byte_valid, rx_line_active, rx_se0, rx_stuff_err,
    input  rx_data, rx_valid, rx_active, rx_error
  );

  modport slave (
    input  rx_byte, rx_byte_valid, rx_line_active, rx_se0, rx_stuff_err,
    output rx_data, rx_valid, rx_active, rx_error
  );

endinterface

// File: rtl/rx_pid_check.sv
// rtl/rx_pid_check.sv - flags a malformed first post-SYNC byte (PID)
module rx_pid_check
  import utmi_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk_60mhz,
  input  logic         rst,
  input  logic         i_arm,
  input  logic         i_byte_seen,
  input  logic [W-1:0] i_byte,
  output logic         o_pid_bad
);

  logic r_first;

  // Armed when SYNC is seen; the next data byte consumes the flag.
  always_ff @(posedge clk_60mhz) begin
    if (rst) begin
      r_first <= 1'b0;
    end else if (i_arm) begin
      r_first <= 1'b1;
    end else if (i_byte_seen) begin
      r_first <= 1'b0;
    end
  end

  assign o_pid_bad = r_first && !pid_ok(i_byte[7:0]);

endmodule

// File: rtl/rx_fsm.sv
// rtl/rx_fsm.sv - UTMI receive packet FSM; optional PID check under RX_PID_CHECK_EN
module rx_fsm
  import utmi_pkg::*;
#(
  parameter int W            = 8,
  parameter int MAX_BYTES    = MAX_BYTES_DEF,
  parameter int IDLE_TIMEOUT = IDLE_TIMEOUT_DEF
) (
  input  logic    clk_60mhz,
  input  logic    rst,
  rx_fsm_if.slave rx_if
);

  localparam int TW = $clog2(IDLE_TIMEOUT + 1);

  rx_state_t         r_state;
  logic [BCNT_W-1:0] r_bcnt;
  logic [TW-1:0]     r_tcnt;
  logic [W-1:0]      r_data;
  logic              r_valid;
  logic              r_active;
  logic              r_error;

  logic w_sync_ok;
  logic w_overrun;
  logic w_idle_expire;
  logic w_pid_bad;
  logic w_err;

  assign w_sync_ok     = rx_if.rx_byte == W'(SYNC_BYTE);
  assign w_overrun     = r_bcnt == BCNT_W'(MAX_BYTES);
  // This idle cycle would be the IDLE_TIMEOUT-th in a row; an EOP in the same cycle ends the packet instead.
  assign w_idle_expire = !rx_if.rx_byte_valid && !rx_if.rx_se0 &&
                         (r_tcnt == TW'(IDLE_TIMEOUT - 1));

`ifdef RX_PID_CHECK_EN
  logic w_arm;
  logic w_byte_seen;

  assign w_arm       = (r_state == RX_SYNC) && rx_if.rx_byte_valid;
  assign w_byte_seen = (r_state == RX_DATA) && rx_if.rx_byte_valid;

  rx_pid_check #(.W(W)) u_pid_check (
    .clk_60mhz   (clk_60mhz),
    .rst         (rst),
    .i_arm       (w_arm),
    .i_byte_seen (w_byte_seen),
    .i_byte      (rx_if.rx_byte),
    .o_pid_bad   (w_pid_bad)
  );
`else
  assign w_pid_bad = 1'b0;
`endif

  // Error conditions per state; a stuff error beats any byte or EOP in the same cycle.
  always_comb begin
    w_err = 1'b0;
    case (r_state)
      RX_SYNC: w_err = rx_if.rx_stuff_err || (rx_if.rx_byte_valid && !w_sync_ok) || w_idle_expire;
      RX_DATA: w_err = rx_if.rx_stuff_err || (rx_if.rx_byte_valid && (w_overrun || w_pid_bad)) ||
                       w_idle_expire;
      default: w_err = 1'b0;
    endcase
  end

  // Packet state machine with registered UTMI outputs.
  always_ff @(posedge clk_60mhz) begin
    if (rst) begin
      r_state  <= RX_WAIT;
      r_bcnt   <= '0;
      r_tcnt   <= '0;
      r_data   <= '0;
      r_valid  <= 1'b0;
      r_active <= 1'b0;
      r_error  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_error <= 1'b0;
      if (w_err) begin
        // An error coinciding with EOP has nothing left to discard, so go straight back to waiting.
        r_error  <= 1'b1;
        r_active <= 1'b0;
        r_tcnt   <= '0;
        r_state  <= rx_if.rx_se0 ? RX_WAIT : RX_ERR;
      end else begin
        case (r_state)
          RX_WAIT: begin
            r_active <= 1'b0;
            if (rx_if.rx_line_active) begin
              r_state <= RX_SYNC;
              r_bcnt  <= '0;
              r_tcnt  <= '0;
            end
          end
          RX_SYNC: begin
            if (rx_if.rx_byte_valid) begin
              r_tcnt   <= '0;
              r_active <= 1'b1;
              r_state  <= rx_if.rx_se0 ? RX_WAIT : RX_DATA;
            end else if (rx_if.rx_se0) begin
              r_state <= RX_WAIT;
            end else begin
              r_tcnt <= r_tcnt + TW'(1);
            end
          end
          RX_DATA: begin
            if (rx_if.rx_byte_valid) begin
              // With a simultaneous EOP, rx_active is left high; RX_WAIT drops it one cycle after rx_valid.
              r_data  <= rx_if.rx_byte;
              r_valid <= 1'b1;
              r_tcnt  <= '0;
              if (r_bcnt != '1) begin
                r_bcnt <= r_bcnt + BCNT_W'(1);
              end
              if (rx_if.rx_se0) begin
                r_state <= RX_WAIT;
              end
            end else if (rx_if.rx_se0) begin
              r_active <= 1'b0;
              r_state  <= RX_WAIT;
            end else begin
              r_tcnt <= r_tcnt + TW'(1);
            end
          end
          RX_ERR: begin
            r_active <= 1'b0;
            if (rx_if.rx_se0) begin
              r_state <= RX_WAIT;
            end
          end
          default: r_state <= RX_WAIT;
        endcase
      end
    end
  end

  assign rx_if.rx_data   = r_data;
  assign rx_if.rx_valid  = r_valid;
  assign rx_if.rx_active = r_active;
  assign rx_if.rx_error  = r_error;

endmodule

// File: tb/tb_rx_fsm.sv
// tb/tb_rx_fsm.sv - directed and randomized bench for rx_fsm
module tb_rx_fsm;

  localparam int MAXB = 4;
  localparam int TMO  = 16;
`ifdef RX_PID_CHECK_EN
  localparam bit PID_EN = 1'b1;
`else
  localparam bit PID_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;

  always #8 clk = ~clk;

  rx_fsm_if #(.W(8)) bus ();

  rx_fsm #(.W(8), .MAX_BYTES(MAXB), .IDLE_TIMEOUT(TMO)) dut (
    .clk_60mhz (clk),
    .rst       (rst),
    .rx_if     (bus.slave)
  );

  int tests = 0;
  int fails = 0;
  logic [7:0] got_q[$];
  int err_cyc;
  int viol;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle of receive-chain input; outputs are sampled 1 time unit after the edge.
  task automatic step(input logic [7:0] b, input logic bv, input logic la, input logic se0, input logic se);
    bus.rx_byte        = b;
    bus.rx_byte_valid  = bv;
    bus.rx_line_active = la;
    bus.rx_se0         = se0;
    bus.rx_stuff_err   = se;
    @(posedge clk);
    #1;
    if (bus.rx_valid) got_q.push_back(bus.rx_data);
    if (bus.rx_error) err_cyc++;
    if (bus.rx_valid && !bus.rx_active) viol++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic clear_obs();
    got_q.delete();
    err_cyc = 0;
    viol    = 0;
  endtask

  function automatic bit pid_good(input logic [7:0] b);
    return b[7:4] == ~b[3:0];
  endfunction

  function automatic int pick_gap();
    int r;
    r = int'($urandom_range(0, 11));
    if (r == 0) return TMO - 1;
    if (r == 1) return TMO;
    return int'($urandom_range(0, 3));
  endfunction

  // Random packet judged at transaction level: which bytes must emerge and whether one error pulse occurs.
  task automatic rand_packet(input int id);
    logic [7:0] sync;
    logic [7:0] mask;
    logic [3:0] p;
    logic [7:0] d[$];
    int         g[$];
    logic [7:0] exp_q[$];
    int         n, g0, gend, stuff_at, exp_err, nmin;
    bit         swl, dead;
    n    = int'($urandom_range(0, 6));
    mask = 8'h01 << $urandom_range(0, 7);
    sync = ($urandom_range(0, 7) == 0) ? (8'h80 ^ mask) : 8'h80;
    for (int i = 0; i < n; i++) begin
      if (i == 0 && PID_EN && $urandom_range(0, 3) != 0) begin
        p = 4'($urandom_range(0, 15));
        d.push_back({~p, p});
      end else begin
        d.push_back(8'($urandom_range(0, 255)));
      end
      g.push_back(pick_gap());
    end
    g0       = pick_gap();
    gend     = pick_gap();
    stuff_at = (n > 0 && $urandom_range(0, 5) == 0) ? int'($urandom_range(0, n - 1)) : -1;
    swl      = (n > 0) && ($urandom_range(0, 3) == 0);

    exp_err = 0;
    dead    = 1'b0;
    if (g0 >= TMO || sync != 8'h80) begin
      exp_err = 1;
      dead    = 1'b1;
    end
    for (int i = 0; i < n; i++) begin
      if (!dead) begin
        if (g[i] >= TMO || i == stuff_at || i >= MAXB || (PID_EN && i == 0 && !pid_good(d[i]))) begin
          exp_err = 1;
          dead    = 1'b1;
        end else begin
          exp_q.push_back(d[i]);
        end
      end
    end
    if (!dead && !swl && gend >= TMO) exp_err = 1;

    clear_obs();
    step(8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(g0);
    step(sync, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < n; i++) begin
      idle(g[i]);
      step(d[i], 1'b1, 1'b0, swl && (i == n - 1), i == stuff_at);
    end
    if (!swl) begin
      idle(gend);
      step(8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    end
    idle(2);

    check($sformatf("rnd%0d_count", id), got_q.size(), exp_q.size());
    nmin = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < nmin; i++) check($sformatf("rnd%0d_byte%0d", id, i), got_q[i], exp_q[i]);
    check($sformatf("rnd%0d_err", id), err_cyc, exp_err);
    check($sformatf("rnd%0d_valid_wo_active", id), viol, 0);
    check($sformatf("rnd%0d_active_end", id), bus.rx_active, 1'b0);
  endtask

  initial begin
    bus.rx_byte        = 8'h00;
    bus.rx_byte_valid  = 1'b0;
    bus.rx_line_active = 1'b0;
    bus.rx_se0         = 1'b0;
    bus.rx_stuff_err   = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_data", bus.rx_data, 8'h00);
    check("rst_valid", bus.rx_valid, 1'b0);
    check("rst_active", bus.rx_active, 1'b0);
    check("rst_error", bus.rx_error, 1'b0);
    rst = 1'b0;
    idle(2);

    // Normal packet, back-to-back bytes
    clear_obs();
    step(8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    check("pkt_active_pre", bus.rx_active, 1'b0);
    step(8'h80, 1'b1, 1'b0, 1'b0, 1'b0);
    check("pkt_active_rise", bus.rx_active, 1'b1);
    check("pkt_no_valid_sync", bus.rx_valid, 1'b0);
    step(8'hC3, 1'b1, 1'b0, 1'b0, 1'b0);
    check("pkt_valid0", bus.rx_valid, 1'b1);
    check("pkt_data0", bus.rx_data, 8'hC3);
    step(8'h11, 1'b1, 1'b0, 1'b0, 1'b0);
    check("pkt_data1", bus.rx_data, 8'h11);
    step(8'h22, 1'b1, 1'b0, 1'b0, 1'b0);
    check("pkt_data2", bus.rx_data, 8'h22);
    check("pkt_active_hold", bus.rx_active, 1'b1);
    step(8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    check("pkt_active_fall", bus.rx_active, 1'b0);
    check("pkt_valid_end", bus.rx_valid, 1'b0);
    idle(2);
    check("pkt_bytes", got_q.size(), 3);
    check("pkt_no_err", err_cyc, 0);

    // Bad SYNC
    clear_obs();
    step(8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    step(8'h40, 1'b1, 1'b0, 1'b0, 1'b0);
    check("bsync_err", bus.rx_error, 1'b1);
    check("bsync_active", bus.rx_active, 1'b0);
    step(8'h80, 1'b1, 1'b0, 1'b0, 1'b0);
    check("bsync_err_pulse", bus.rx_error, 1'b0);
    step(8'hC3, 1'b1, 1'b0, 1'b0, 1'b0);
    check("bsync_discard", bus.rx_valid, 1'b0);
    step(8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(1);
    check("bsync_no_active", viol + int'(bus.rx_active), 0);
    step(8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    step(8'h80, 1'b1, 1'b0, 1'b0, 1'b0);
    step(8'hC3, 1'b1, 1'b0, 1'b0, 1'b0);
    check("bsync_recover", bus.rx_valid, 1'b1);
    step(8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(1);

    // Stuff error after two data bytes
    clear_obs();
    step(8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    step(8'h80, 1'b1, 1'b0, 1'b0, 1'b0);
    step(8'hC3, 1'b1, 1'b0, 1'b0, 1'b0);
    step(8'h11, 1'b1, 1'b0, 1'b0, 1'b0);
    step(8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    check("stuff_err", bus.rx_error, 1'b1);
    check("stuff_active", bus.rx_active, 1'b0);
    step(8'h22, 1'b1, 1'b0, 1'b0, 1'b0);
    step(8'h33, 1'b1, 1'b0, 1'b0, 1'b0);
    step(8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(1);
    check("stuff_bytes", got_q.size(), 2);
    check("stuff_err_cycles", err_cyc, 1);

    // Overrun with MAXB data bytes allowed
    clear_obs();
    step(8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    step(8'h80, 1'b1, 1'b0, 1'b0, 1'b0);
    step(8'hC3, 1'b1, 1'b0, 1'b0, 1'b0);
    step(8'h11, 1'b1, 1'b0, 1'b0, 1'b0);
    step(8'h22, 1'b1, 1'b0, 1'b0, 1'b0);
    step(8'h33, 1'b1, 1'b0, 1'b0, 1'b0);
    check("ovr_last_ok", bus.rx_valid, 1'b1);
    step(8'h44, 1'b1, 1'b0, 1'b0, 1'b0);
    check("ovr_err", bus.rx_error, 1'b1);
    check("ovr_no_valid", bus.rx_valid, 1'b0);
    check("ovr_active", bus.rx_active, 1'b0);
    step(8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(1);
    check("ovr_bytes", got_q.size(), MAXB);

    // Stall: timeout on the 16th idle cycle, not the 15th
    clear_obs();
    step(8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    step(8'h80, 1'b1, 1'b0, 1'b0, 1'b0);
    step(8'hC3, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int j = 1; j <= TMO; j++) begin
      step(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      if (j == TMO - 1) check("stall_not_yet", bus.rx_error, 1'b0);
      if (j == TMO) begin
        check("stall_err", bus.rx_error, 1'b1);
        check("stall_active", bus.rx_active, 1'b0);
      end
    end
    step(8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(1);

    // Byte and EOP in the same cycle
    step(8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    step(8'h80, 1'b1, 1'b0, 1'b0, 1'b0);
    step(8'hC3, 1'b1, 1'b0, 1'b0, 1'b0);
    step(8'h55, 1'b1, 1'b0, 1'b1, 1'b0);
    check("sim_valid", bus.rx_valid, 1'b1);
    check("sim_data", bus.rx_data, 8'h55);
    check("sim_active_hold", bus.rx_active, 1'b1);
    step(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    check("sim_active_fall", bus.rx_active, 1'b0);
    check("sim_valid_end", bus.rx_valid, 1'b0);
    idle(1);

    // SYNC directly followed by EOP
    clear_obs();
    step(8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    step(8'h80, 1'b1, 1'b0, 1'b0, 1'b0);
    check("se_active", bus.rx_active, 1'b1);
    step(8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    check("se_active_fall", bus.rx_active, 1'b0);
    idle(1);
    check("se_quiet", got_q.size() + err_cyc, 0);

    // PID handling
    step(8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    step(8'h80, 1'b1, 1'b0, 1'b0, 1'b0);
    step(8'hC4, 1'b1, 1'b0, 1'b0, 1'b0);
    check("pid_err", bus.rx_error, PID_EN);
    check("pid_valid", bus.rx_valid, !PID_EN);
    step(8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(1);

    // Reset in the middle of a packet
    step(8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    step(8'h80, 1'b1, 1'b0, 1'b0, 1'b0);
    step(8'hC3, 1'b1, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    step(8'h11, 1'b1, 1'b0, 1'b0, 1'b1);
    check("mrst_valid", bus.rx_valid, 1'b0);
    check("mrst_active", bus.rx_active, 1'b0);
    check("mrst_error", bus.rx_error, 1'b0);
    check("mrst_data", bus.rx_data, 8'h00);
    rst = 1'b0;
    idle(2);

    for (int r = 0; r < 60; r++) rand_packet(r);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rx_fsm.md
# rx_fsm

Receive-side packet state machine of the UTMI block, in the 60 MHz domain. Consumes byte strobes from the receive chain (NRZI decoder, bit unstuffer, receive shift register), validates and strips the SYNC byte, and forwards packet bytes to the link layer as UTMI RxData/RxValid/RxActive/RxError. Detects EOP, bit-stuff errors, packet overrun and mid-packet stalls.

## Interface
Parameters:
- W, 8: byte width.
- MAX_BYTES, 1027: maximum post-SYNC bytes per packet (PID + 1024 payload + CRC16).
- IDLE_TIMEOUT, 16: clk_60mhz cycles allowed between bytes once a packet has started.

Ports:
- clk_60mhz  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- rx_byte  in  W  deserialized byte, LSB received first.
- rx_byte_valid  in  1  one-cycle strobe; rx_byte is valid.
- rx_line_active  in  1  line transitions seen (packet start).
- rx_se0  in  1  EOP (SE0) detected on the line; one-cycle pulse.
- rx_stuff_err  in  1  bit-unstuff error (seven consecutive ones); one-cycle pulse.
- rx_data  out  W  received byte.
- rx_valid  out  1  rx_data valid, one cycle per byte.
- rx_active  out  1  packet in progress (SYNC accepted, EOP/error not yet reached).
- rx_error  out  1  one-cycle error pulse.

## Operation
- States: RX_WAIT, RX_SYNC, RX_DATA, RX_ERR.
- RX_WAIT: rx_line_active=1 -> RX_SYNC; clear byte and timeout counters.
- RX_SYNC: first rx_byte_valid with rx_byte==SYNC_BYTE (8'h80) -> RX_DATA, assert rx_active; any other value -> RX_ERR. rx_se0 before a byte -> RX_WAIT silently (no rx_active, no rx_error).
- RX_DATA: each rx_byte_valid -> rx_data<=rx_byte, rx_valid=1, byte counter +1. rx_se0 -> RX_WAIT, deassert rx_active.
- Errors in RX_SYNC/RX_DATA: rx_stuff_err; byte counter already equal to MAX_BYTES when another byte arrives; timeout counter reaching IDLE_TIMEOUT with no rx_byte_valid. Each -> RX_ERR with rx_error pulse.
- RX_ERR: rx_active=0; remain until rx_se0, then RX_WAIT. Bytes in RX_ERR are discarded.
- Byte counter: 11 bits, saturating, cleared on entry to RX_SYNC. Timeout counter: cleared on each rx_byte_valid; runs only in RX_SYNC/RX_DATA.
- Simultaneous events:
  - rx_byte_valid + rx_se0: byte delivered, then packet ends; rx_active drops one cycle after rx_valid.
  - rx_byte_valid + rx_stuff_err: error wins, byte dropped.
  - rx_se0 + rx_stuff_err: error wins.
- SYNC followed directly by EOP: rx_active pulses; no rx_valid; no error.

## Timing
- Reset values: rx_data=0, rx_valid=0, rx_active=0, rx_error=0, state RX_WAIT, all counters 0. Reset mid-packet takes effect on the next edge; no trailing rx_valid/rx_error.
- All outputs registered.
- rx_active rises the cycle after the SYNC strobe.
- rx_valid/rx_data follow their rx_byte_valid by 1 cycle.
- rx_active falls 1 cycle after rx_se0.
- rx_error and rx_active fall: both 1 cycle after the error event.
- rx_valid is never asserted while rx_active=0.
- Back-to-back rx_byte_valid (every cycle) must be sustained without loss.

## Configuration
- RX_PID_CHECK_EN defined: the first post-SYNC byte is checked so that rx_byte[7:4] == ~rx_byte[3:0]. On mismatch the PID is not delivered, and the block emits an rx_error pulse and enters RX_ERR.
- RX_PID_CHECK_EN undefined: the PID is forwarded unchecked like any data byte.

## Structure
- Shared package `utmi_pkg`:
  - state enum (`rx_state_t`)
  - `SYNC_BYTE` = 8'h80
  - default `MAX_BYTES` and `IDLE_TIMEOUT` constants
- One sub-module, `rx_pid_check` (combinational PID complement check plus registered first-byte flag), instantiated only under RX_PID_CHECK_EN.

## Test plan
- Packet: line_active, bytes 80,C3,11,22 then se0 -> rx_active high for 3 data cycles; rx_valid with C3,11,22; rx_active low 1 cycle after se0; rx_error never.
- Bad SYNC: first byte 0x40 -> rx_error 1-cycle pulse; rx_active never rises; state returns to RX_WAIT after se0.
- Stuff error after 2 data bytes -> rx_error pulse; rx_active low next cycle; later bytes ignored until se0.
- Overrun: MAX_BYTES=4; send 80 then 5 bytes -> 4 rx_valid, then rx_error on the 5th byte.
- Stall: 80,C3, then 16 idle cycles -> rx_error at timeout. Simultaneous byte 0x55 + se0 -> rx_valid 0x55, then rx_active falls.
- RX_PID_CHECK_EN: PID 0xC4 -> rx_error, no rx_valid. Reset asserted mid-packet -> all outputs 0 next cycle.
